// File: rtl/scr1_dmem_responder.sv
// ============================================================================
// Module   : scr1_dmem_responder
// Brief    : Memory-side responder for the SCR1 DMEM request/response
//            protocol. It accepts one load or store at a time, accesses a
//            word-organised data array with byte-lane steering, and returns
//            an OK or error response after WAIT_CYCLES wait states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_memif_pkg;
   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_responder
   import scr1_memif_pkg::*;
#(
   parameter int unsigned              DEPTH_WORDS = 1024,
   parameter logic [`SCR1_DMEM_AWIDTH-1:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned              WAIT_CYCLES = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          dmem_req_i,
   input  type_scr1_mem_cmd_e            dmem_cmd_i,
   input  type_scr1_mem_width_e          dmem_width_i,
   input  logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr_i,
   input  logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_wdata_i,
   output logic                          dmem_req_ack_o,
   output logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_rdata_o,
   output type_scr1_mem_resp_e           dmem_resp_o
);

   // Offset bits covering the whole array (byte granularity).
   localparam int unsigned c_IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned c_OFF_W = c_IDX_W + 2;
   // Down-counter start value; the counter ticks once per WAIT cycle.
   localparam logic [3:0]  c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e                          r_state;
   logic [3:0]                      r_cnt;
   logic                            r_err;
   logic [`SCR1_DMEM_DWIDTH-1:0]    r_load;
   type_scr1_mem_resp_e             r_resp;
   logic [`SCR1_DMEM_DWIDTH-1:0]    r_rdata;
   logic [31:0]                     r_mem [DEPTH_WORDS];

   logic [`SCR1_DMEM_AWIDTH-1:0]    w_off;
   logic [c_IDX_W-1:0]              w_idx;
   logic [1:0]                      w_lane;
   logic                            w_range_err;
   logic                            w_misalign;
   logic                            w_err;
   logic                            w_accept;
   logic                            w_we;
   logic [3:0]                      w_be;
   logic [31:0]                     w_wsh;
   logic [31:0]                     w_word;
   logic [31:0]                     w_shr;
   logic [31:0]                     w_load;
   logic [31:0]                     w_load_q;

   // BASE_ADDR is aligned to the array size, so the low offset bits equal
   // the low address bits and anything above the array span is out of range.
   assign w_off       = dmem_addr_i - BASE_ADDR;
   assign w_idx       = w_off[c_OFF_W-1:2];
   assign w_lane      = w_off[1:0];
   assign w_range_err = |w_off[`SCR1_DMEM_AWIDTH-1:c_OFF_W];
   assign w_err       = w_range_err | w_misalign;

   assign w_accept = (r_state == ST_IDLE) & dmem_req_i;
   // Stores are gated off while reset is held so the array stays untouched.
   assign w_we     = w_accept & rst_n & (dmem_cmd_i == SCR1_MEM_CMD_WR) & ~w_err;

   assign w_wsh  = dmem_wdata_i << {w_lane, 3'b000};
   assign w_word = r_mem[w_idx];
   assign w_shr  = w_word >> {w_lane, 3'b000};

   // Decode byte enables, alignment and load masking from width and lane.
   always_comb begin
      w_be       = 4'b0000;
      w_misalign = 1'b0;
      w_load     = 32'h0;
      case (dmem_width_i)
         SCR1_MEM_WIDTH_BYTE: begin
            w_be   = 4'b0001 << w_lane;
            w_load = {24'h0, w_shr[7:0]};
         end
         SCR1_MEM_WIDTH_HWORD: begin
            w_be       = 4'b0011 << w_lane;
            w_misalign = w_lane[0];
            w_load     = {16'h0, w_shr[15:0]};
         end
         SCR1_MEM_WIDTH_WORD: begin
            w_be       = 4'b1111;
            w_misalign = |w_lane;
            w_load     = w_shr;
         end
         default: begin
            // Unencoded width is treated as an erroneous access.
            w_misalign = 1'b1;
         end
      endcase
   end

   // Only a successful read carries data; errors and stores return zero.
   assign w_load_q = ((dmem_cmd_i == SCR1_MEM_CMD_RD) && !w_err) ? w_load : 32'h0;

   // Data array: stores commit on the accept edge, per enabled byte lane.
   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
            end
         end
      end
   end

   // Transaction FSM with registered response and load data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_err   <= 1'b0;
         r_load  <= '0;
         r_resp  <= SCR1_MEM_RESP_NOTRDY;
         r_rdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (dmem_req_i) begin
                  r_err  <= w_err;
                  r_load <= w_load_q;
                  if (WAIT_CYCLES == 0) begin
                     r_state <= ST_RESP;
                     r_resp  <= w_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                     r_rdata <= w_load_q;
                  end else begin
                     r_state <= ST_WAIT;
                     r_cnt   <= c_WAIT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_RESP;
                  r_resp  <= r_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                  r_rdata <= r_load;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_resp  <= SCR1_MEM_RESP_NOTRDY;
               r_rdata <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_resp  <= SCR1_MEM_RESP_NOTRDY;
               r_rdata <= '0;
            end
         endcase
      end
   end

   assign dmem_req_ack_o = (r_state == ST_IDLE);
   assign dmem_resp_o    = r_resp;
   assign dmem_rdata_o   = r_rdata;

endmodule

`default_nettype wire
